// File: rtl/pipeline_pkg.sv
// Shared pipeline types: fetch FSM encoding, IF/ID payload and the bubble/flush word.
package pipeline_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [INSTR_W-1:0] NOP_BUBBLE = '0;

    typedef enum logic [2:0] {
        FS_IDLE,
        FS_REQ,
        FS_WAIT,
        FS_HOLD,
        FS_DROP
    } fetch_state_e;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] pc);
        return pc & ~PC_W'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory request/response channel between fetch (master) and imem (slave).
interface fetch_unit_if;
    import pipeline_pkg::*;

    logic               req;
    logic [PC_W-1:0]    addr;
    logic               ready;
    logic               rvalid;
    logic [INSTR_W-1:0] rdata;

    modport master (output req, addr, input ready, rvalid, rdata);
    modport slave  (input req, addr, output ready, rvalid, rdata);

endinterface

// File: rtl/fetch_out_buf.sv
// Presented-instruction register plus a one-entry skid for a response that arrives while IF/ID stalls.
module fetch_out_buf
    import pipeline_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               load,
    input  fetch_entry_t       load_entry,
    input  logic               consume,
    input  logic               clear,
    input  logic               skid_load,
    input  logic [INSTR_W-1:0] skid_data,
    input  logic               skid_clear,
    output logic               valid,
    output fetch_entry_t       entry,
    output logic [INSTR_W-1:0] skid
);

    // Clear beats load beats consume; a freed entry keeps its pc but drops to the bubble word.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid <= 1'b0;
            entry <= '0;
            skid  <= NOP_BUBBLE;
        end else begin
            if (clear) begin
                valid       <= 1'b0;
                entry.instr <= NOP_BUBBLE;
            end else if (load) begin
                valid <= 1'b1;
                entry <= load_entry;
            end else if (consume) begin
                valid       <= 1'b0;
                entry.instr <= NOP_BUBBLE;
            end

            if (clear || skid_clear) begin
                skid <= NOP_BUBBLE;
            end else if (skid_load) begin
                skid <= skid_data;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// IF stage: owns the PC, keeps one imem request in flight and feeds {pc, instr, valid} to IF/ID.
module fetch_unit
    import pipeline_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned     PC_STEP  = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic               stall_i,
    input  logic               redirect_i,
    input  logic [PC_W-1:0]    redirect_pc_i,
    fetch_unit_if.master       imem,
    output logic [PC_W-1:0]    pc_o,
    output logic [INSTR_W-1:0] instr_o,
    output logic               valid_o
);

    fetch_state_e       state_q;
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    pc_inc;

    logic               out_valid;
    fetch_entry_t       out_entry;
    logic [INSTR_W-1:0] skid_instr;
    fetch_entry_t       load_entry;

    logic consume;
    logic wait_rsp;
    logic rsp_load;
    logic skid_load;
    logic hold_load;
    logic buf_load;

    assign pc_inc    = pc_q + PC_W'(PC_STEP);
    assign consume   = out_valid && !stall_i && !redirect_i;
    assign wait_rsp  = (state_q == FS_WAIT) && imem.rvalid && !redirect_i;
    assign rsp_load  = wait_rsp && (!out_valid || consume);
    assign skid_load = wait_rsp && out_valid && !consume;
    assign hold_load = (state_q == FS_HOLD) && consume;
    assign buf_load  = rsp_load || hold_load;

    assign load_entry = '{pc: pc_q, instr: (hold_load ? skid_instr : imem.rdata)};

    assign imem.req  = (state_q == FS_REQ);
    assign imem.addr = word_align(pc_q);

    assign pc_o    = out_entry.pc;
    assign instr_o = out_entry.instr;
    assign valid_o = out_valid;

    fetch_out_buf u_out_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .load       (buf_load),
        .load_entry (load_entry),
        .consume    (consume),
        .clear      (redirect_i),
        .skid_load  (skid_load),
        .skid_data  (imem.rdata),
        .skid_clear (hold_load),
        .valid      (out_valid),
        .entry      (out_entry),
        .skid       (skid_instr)
    );

    // Redirect overrides every normal transition; an accepted-but-unanswered request parks in DROP.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= FS_IDLE;
            pc_q    <= RESET_PC;
        end else if (redirect_i) begin
            pc_q <= word_align(redirect_pc_i);
            case (state_q)
                FS_REQ:  state_q <= imem.ready  ? FS_DROP : FS_REQ;
                FS_WAIT: state_q <= imem.rvalid ? FS_REQ  : FS_DROP;
                FS_HOLD: state_q <= FS_REQ;
                FS_DROP: state_q <= FS_DROP;
                default: state_q <= FS_IDLE;
            endcase
        end else begin
            case (state_q)
                FS_IDLE: begin
                    if (start_i) state_q <= FS_REQ;
                end
                FS_REQ: begin
                    if (imem.ready) state_q <= FS_WAIT;
                end
                FS_WAIT: begin
                    if (imem.rvalid) begin
                        if (rsp_load) begin
                            pc_q    <= pc_inc;
                            state_q <= FS_REQ;
                        end else begin
                            state_q <= FS_HOLD;
                        end
                    end
                end
                FS_HOLD: begin
                    if (hold_load) begin
                        pc_q    <= pc_inc;
                        state_q <= FS_REQ;
                    end
                end
                FS_DROP: begin
                    if (imem.rvalid) state_q <= FS_REQ;
                end
                default: state_q <= FS_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed corner cases, then randomized memory/stall/redirect traffic.
module tb_fetch_unit;
    import pipeline_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_i, start_i, stall_i, redirect_i;
    logic [31:0] redirect_pc_i;
    logic [31:0] pc_o, instr_o;
    logic        valid_o;
    logic [31:0] w_pc, w_instr;
    logic        w_valid;

    always #5 clk_i = ~clk_i;

    fetch_unit_if imem ();
    fetch_unit_if imem_w ();

    fetch_unit #(.RESET_PC(32'h0000_0000), .PC_STEP(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(stall_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .imem(imem),
        .pc_o(pc_o), .instr_o(instr_o), .valid_o(valid_o)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .PC_STEP(4)) dut_w (
        .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .stall_i(1'b0),
        .redirect_i(1'b0), .redirect_pc_i(32'h0), .imem(imem_w),
        .pc_o(w_pc), .instr_o(w_instr), .valid_o(w_valid)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        sbq[$];
    logic [31:0] gen_pc = 32'h0;
    bit          rand_mem = 1'b0;
    int          fix_lat = 1;
    logic [31:0] w_addrs[$];
    logic [31:0] w_pcs[$];
    logic [31:0] w_ins[$];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h0010_0093 ^ (a * 32'h0001_0003);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic timeout(input string name);
        vectors++;
        miscompares++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Reference model: program order restarts at the reset PC or a redirect target, then walks +4.
    task automatic model_restart(input logic [31:0] pc);
        sbq.delete();
        gen_pc = pc;
        while (sbq.size() < 8) begin
            sbq.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
            gen_pc = gen_pc + 32'd4;
        end
    endtask

    initial forever begin
        @(posedge clk_i);
        #1;
        while (sbq.size() < 8) begin
            sbq.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
            gen_pc = gen_pc + 32'd4;
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic wait_accept(input int max, output bit found, output logic [31:0] addr);
        found = 1'b0;
        addr  = '0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_i);
            if (imem.req === 1'b1 && imem.ready === 1'b1) begin
                found = 1'b1;
                addr  = imem.addr;
                break;
            end
        end
    endtask

    task automatic wait_valid(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            @(negedge clk_i);
            if (valid_o === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
    endtask

    // Memory model for the main DUT: one request at a time, fixed or random latency and ready.
    bit          acc, pend;
    int          cnt;
    logic [31:0] acc_addr, pdata;
    initial begin
        imem.ready = 1'b1; imem.rvalid = 1'b0; imem.rdata = '0;
        pend = 1'b0; cnt = 0; pdata = '0;
        forever begin
            @(negedge clk_i);
            acc      = (imem.req === 1'b1) && (imem.ready === 1'b1);
            acc_addr = imem.addr;
            @(posedge clk_i);
            #1;
            imem.rvalid = 1'b0;
            imem.rdata  = $urandom;
            if (acc) begin
                check("one_outstanding", 32'(pend), 32'd0);
                pend  = 1'b1;
                cnt   = rand_mem ? int'($urandom_range(1, 3)) : fix_lat;
                pdata = mem_word(acc_addr);
            end
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem.rvalid = 1'b1;
                    imem.rdata  = pdata;
                    pend        = 1'b0;
                end
            end
            imem.ready = rand_mem ? ($urandom_range(0, 9) < 7) : 1'b1;
        end
    end

    // Zero-wait memory for the wrap-around instance; records its first requests and outputs.
    bit          wacc;
    logic [31:0] wa;
    initial begin
        imem_w.ready = 1'b1; imem_w.rvalid = 1'b0; imem_w.rdata = '0;
        forever begin
            @(negedge clk_i);
            wacc = (imem_w.req === 1'b1);
            wa   = imem_w.addr;
            if (wacc && w_addrs.size() < 2) w_addrs.push_back(wa);
            if (w_valid === 1'b1 && w_pcs.size() < 2) begin
                w_pcs.push_back(w_pc);
                w_ins.push_back(w_instr);
            end
            @(posedge clk_i);
            #1;
            imem_w.rvalid = wacc;
            imem_w.rdata  = mem_word(wa);
        end
    end

    // Scoreboard monitor: every consumed instruction must be the next one in program order.
    exp_t e;
    initial forever begin
        @(negedge clk_i);
        if (rst_i !== 1'b0) continue;
        if (valid_o !== 1'b1) begin
            check("bubble_instr", instr_o, NOP_BUBBLE);
        end else if (stall_i === 1'b0 && redirect_i === 1'b0) begin
            if (sbq.size() == 0) begin
                timeout("sb_empty");
            end else begin
                e = sbq.pop_front();
                check("sb_pc", pc_o, e.pc);
                check("sb_instr", instr_o, e.instr);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    bit          ok;
    logic [31:0] a;
    logic [31:0] tgt;
    initial begin
        rst_i = 1'b1; start_i = 1'b0; stall_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        step(); step();
        rst_i = 1'b0;
        model_restart(32'h0);
        @(negedge clk_i);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_instr", instr_o, 32'd0);
        check("rst_pc", pc_o, 32'd0);
        check("rst_req", 32'(imem.req), 32'd0);
        step();
        @(negedge clk_i);
        check("idle_no_req", 32'(imem.req), 32'd0);

        // Zero-wait streaming: one instruction every two cycles.
        step(); start_i = 1'b1;
        step(); start_i = 1'b0;
        wait_valid(20, ok);
        if (!ok) timeout("first_valid");
        for (int k = 0; k < 4; k++) begin
            check("zw_valid", 32'(valid_o), 32'd1);
            check("zw_pc", pc_o, 32'(k * 4));
            check("zw_instr", instr_o, mem_word(32'(k * 4)));
            @(negedge clk_i);
            check("zw_gap", 32'(valid_o), 32'd0);
            @(negedge clk_i);
        end
        check("wrap_req_count", 32'(w_addrs.size()), 32'd2);
        if (w_addrs.size() == 2) begin
            check("wrap_addr0", w_addrs[0], 32'hFFFF_FFFC);
            check("wrap_addr1", w_addrs[1], 32'h0000_0000);
        end
        check("wrap_out_count", 32'(w_pcs.size()), 32'd2);
        if (w_pcs.size() == 2) begin
            check("wrap_pc0", w_pcs[0], 32'hFFFF_FFFC);
            check("wrap_pc1", w_pcs[1], 32'h0000_0000);
            check("wrap_instr0", w_ins[0], mem_word(32'hFFFF_FFFC));
        end

        // Skid: stall while the next response lands; it must surface after the stall.
        step(); redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; model_restart(32'hFFFF_FFFC);
        step(); redirect_i = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (imem.req === 1'b1 && imem.ready === 1'b1 && imem.addr === 32'hFFFF_FFFC) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) timeout("skid_accept");
        step(); stall_i = 1'b1;
        @(negedge clk_i);
        check("skid_pre_valid", 32'(valid_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("skid_hold_valid", 32'(valid_o), 32'd1);
            check("skid_hold_pc", pc_o, 32'hFFFF_FFFC);
            check("skid_hold_instr", instr_o, mem_word(32'hFFFF_FFFC));
            if (i > 0) check("skid_no_req", 32'(imem.req), 32'd0);
        end
        step(); stall_i = 1'b0;
        @(negedge clk_i);
        check("skid_release_pc", pc_o, 32'hFFFF_FFFC);
        @(negedge clk_i);
        check("skid_out_valid", 32'(valid_o), 32'd1);
        check("skid_out_pc", pc_o, 32'h0000_0000);
        check("skid_out_instr", instr_o, 32'h0010_0093);

        // Redirect in WAIT before rvalid: DROP swallows the late response.
        fix_lat = 3;
        wait_accept(20, ok, a);
        if (!ok) timeout("drop_accept");
        step(); redirect_i = 1'b1; redirect_pc_i = 32'h0000_0040; model_restart(32'h40);
        step(); redirect_i = 1'b0;
        @(negedge clk_i);
        check("drop_valid", 32'(valid_o), 32'd0);
        check("drop_instr", instr_o, 32'd0);
        check("drop_no_req", 32'(imem.req), 32'd0);
        wait_accept(20, ok, a);
        if (!ok) timeout("drop_next_req");
        else check("drop_next_addr", a, 32'h0000_0040);

        // Redirect plus stall on the rvalid cycle: response dropped, straight back to REQ.
        fix_lat = 1;
        wait_accept(20, ok, a);
        if (!ok) timeout("rs_accept");
        step(); redirect_i = 1'b1; stall_i = 1'b1; redirect_pc_i = 32'h0000_0083; model_restart(32'h80);
        step(); redirect_i = 1'b0; stall_i = 1'b0;
        @(negedge clk_i);
        check("rs_valid", 32'(valid_o), 32'd0);
        check("rs_req", 32'(imem.req), 32'd1);
        check("rs_addr", imem.addr, 32'h0000_0080);

        // Reset in WAIT with the response landing one cycle later.
        fix_lat = 2;
        wait_accept(20, ok, a);
        if (!ok) timeout("rst_accept");
        step(); rst_i = 1'b1; model_restart(32'h0);
        step(); rst_i = 1'b0;
        @(negedge clk_i);
        check("mrst_valid", 32'(valid_o), 32'd0);
        check("mrst_instr", instr_o, 32'd0);
        check("mrst_pc", pc_o, 32'd0);
        check("mrst_req", 32'(imem.req), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("mrst_idle_req", 32'(imem.req), 32'd0);
            check("mrst_idle_valid", 32'(valid_o), 32'd0);
        end
        step(); start_i = 1'b1;
        step(); start_i = 1'b0;
        wait_valid(20, ok);
        if (!ok) timeout("mrst_restart");
        else check("mrst_restart_pc", pc_o, 32'd0);

        // Randomized traffic against the program-order model.
        rand_mem = 1'b1;
        for (int n = 0; n < 2000; n++) begin
            step();
            if ($urandom_range(0, 299) == 0) begin
                rst_i = 1'b1; stall_i = 1'b0; redirect_i = 1'b0; start_i = 1'b0;
                model_restart(32'h0);
                step(); rst_i = 1'b0;
                repeat (4) step();
                start_i = 1'b1;
                step(); start_i = 1'b0;
            end else begin
                stall_i    = ($urandom_range(0, 9) < 3);
                start_i    = ($urandom_range(0, 19) == 0);
                redirect_i = ($urandom_range(0, 24) == 0);
                if (redirect_i) begin
                    tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF0 : (32'($urandom_range(0, 63)) << 2);
                    redirect_pc_i = tgt | 32'($urandom_range(0, 3));
                    model_restart(tgt);
                end
            end
        end
        step(); stall_i = 1'b0; redirect_i = 1'b0; start_i = 1'b0;
        repeat (20) step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
